truth_table_scanner: RTL and testbench

//  Sequential reader for a 4-input combinational logic function under test.
//  - Drives all 16 input vectors {a,b,c,d} (a = MSB) in ascending order.
//  - Waits a settle time per vector, then samples f into a 16-bit truth table.
//  - Compares the table bit-by-bit with an expected mask and reports pass/fail.
//  - Replaces hand-written stimulus lists with on-chip self-check of function blocks.

---
 rtl/truth_table_scanner.sv | 153 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Walks a 4-input combinational block through all 16 input vectors
//   {a,b,c,d} (a = MSB) in ascending order. Each vector is held for
//   SETTLE_CYCLES clocks, then f is captured into a 16-bit truth table and
//   compared against EXPECTED.
//
//   Optional feature macro: TRUTH_TABLE_SCANNER_FIRST_FAIL_EN
//     defined   - first_fail / fail_valid report the lowest mismatching vector
//     undefined - first_fail = 0, fail_valid = 0, no registers built
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        one-cycle scan request, honoured only in IDLE
//   f            response of the function under test
//   a,b,c,d      registered stimulus vector, a = MSB
//   busy         scan in progress (through the DONE cycle)
//   done         one-cycle completion pulse
//   pass         captured table equals EXPECTED
//   truth_tbl    captured table, bit i = f for vector i
//   mismatches   count of differing bits, 0..16
//   first_fail   lowest mismatching vector index
//   fail_valid   at least one mismatch captured
//
// state  | meaning
// IDLE   | stimulus at 0, waiting for start
// SETTLE | vector idx driven, settle counter running down
// SAMPLE | capture f for vector idx, advance or finish
// DONE   | publish pass, then return to IDLE
module truth_table_scanner #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [15:0] EXPECTED      = 16'h87B6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_tbl,
  output logic [4:0]  mismatches,
  output logic [3:0]  first_fail,
  output logic        fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [7:0] settle_cnt;
  logic       f_one, f_zero, f_miss, last_vec, accept;

  // An unknown f fails both equality tests, so it reads as 0 and always
  // counts as a mismatch regardless of the expected bit.
  always_comb begin
    f_one  = 1'b0;
    f_zero = 1'b0;
    if (f == 1'b1) f_one  = 1'b1;
    if (f == 1'b0) f_zero = 1'b1;
  end

  assign f_miss   = EXPECTED[idx] ? ~f_one : ~f_zero;
  assign last_vec = (idx == 4'd15);
  assign accept   = (state == S_IDLE) && start;

  // idx doubles as the stimulus register; it is 0 whenever the scanner is idle.
  assign {a, b, c, d} = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == 8'd0) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_vec ? S_DONE : S_SETTLE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 4'd0;
      settle_cnt <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      truth_tbl  <= 16'h0000;
      mismatches <= 5'd0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            idx        <= 4'd0;
            settle_cnt <= SETTLE_LOAD;
            truth_tbl  <= 16'h0000;
            mismatches <= 5'd0;
            pass       <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
        end
        S_SAMPLE: begin
          truth_tbl[idx] <= f_one;
          if (f_miss) mismatches <= mismatches + 5'd1;
          if (!last_vec) begin
            idx        <= idx + 4'd1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        S_DONE: begin
          // mismatches already includes the final sample here
          pass <= (mismatches == 5'd0);
          idx  <= 4'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef TRUTH_TABLE_SCANNER_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail <= 4'd0;
      fail_valid <= 1'b0;
    end else if (accept) begin
      first_fail <= 4'd0;
      fail_valid <= 1'b0;
    end else if ((state == S_SAMPLE) && f_miss && !fail_valid) begin
      first_fail <= idx;
      fail_valid <= 1'b1;
    end
  end
`else
  assign first_fail = 4'd0;
  assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
`timescale 1ns/1ps
// Two scanners run side by side: one with the default settle time, one with a
// single settle cycle. A scan-level model predicts every output on each
// falling edge from "edges since the accepting edge" and the function table
// that was in force when the scan was accepted.
module tb_truth_table_scanner;

  localparam logic [15:0] EXP = 16'h87B6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       start = 2'b00;
  logic [1:0]       f;
  logic [1:0][15:0] ftab = '0;
  logic [1:0][3:0]  vec;
  logic [1:0]       busy, done, pass, fv;
  logic [1:0][15:0] tbl;
  logic [1:0][4:0]  mism;
  logic [1:0][3:0]  ff;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          mk [2]   = '{-1, -1};
  logic [15:0] stab [2] = '{16'h0000, 16'h0000};
  logic [15:0] ref_tab;

  always #5 clk = ~clk;

  assign f[0] = ftab[0][vec[0]];
  assign f[1] = ftab[1][vec[1]];

  truth_table_scanner #(.SETTLE_CYCLES(4), .EXPECTED(EXP)) dut4 (
    .clk(clk), .rst(rst), .start(start[0]), .f(f[0]),
    .a(vec[0][3]), .b(vec[0][2]), .c(vec[0][1]), .d(vec[0][0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .truth_tbl(tbl[0]),
    .mismatches(mism[0]), .first_fail(ff[0]), .fail_valid(fv[0]));

  truth_table_scanner #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .f(f[1]),
    .a(vec[1][3]), .b(vec[1][2]), .c(vec[1][1]), .d(vec[1][0]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .truth_tbl(tbl[1]),
    .mismatches(mism[1]), .first_fail(ff[1]), .fail_valid(fv[1]));

  function automatic int per(int d);
    return (d == 0) ? 5 : 2;
  endfunction

  function automatic int span(int d);
    return 16 * per(d);
  endfunction

  task automatic chk(string name, int d, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
    end
  endtask

  // Model: k = edges since the accepting edge (-1 = nothing since reset).
  // The scanner is idle before an edge when k<0 or k>=span+1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk[0] <= -1;
      mk[1] <= -1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if ((mk[d] < 0 || mk[d] >= span(d) + 1) && start[d]) begin
          mk[d]   <= 0;
          stab[d] <= ftab[d];
        end else if (mk[d] >= 0 && mk[d] <= span(d) + 1) begin
          mk[d] <= mk[d] + 1;
        end
      end
    end
  end

  task automatic check_dut(int d);
    int k, L, ns, e_vec, e_mism, e_ff;
    logic [15:0] mask, diff, e_tbl;
    bit e_busy, e_done, e_pass, e_fv;
    k = mk[d];
    L = span(d);
    e_vec = 0; e_mism = 0; e_ff = 0; e_tbl = 16'h0000;
    e_busy = 0; e_done = 0; e_pass = 0; e_fv = 0;
    if (k >= 0) begin
      ns     = (k >= L) ? 16 : k / per(d);
      mask   = (ns == 16) ? 16'hFFFF : 16'((1 << ns) - 1);
      e_tbl  = stab[d] & mask;
      diff   = (stab[d] ^ EXP) & mask;
      e_mism = $countones(diff);
      e_busy = (k <= L);
      e_done = (k == L + 1);
      e_pass = (k >= L + 1) && (diff == 16'h0000);
      e_vec  = (k < L) ? k / per(d) : ((k == L) ? 15 : 0);
      for (int i = 0; i < 16; i++)
        if (diff[i] && !e_fv) begin
          e_ff = i;
          e_fv = 1;
        end
    end
`ifndef TRUTH_TABLE_SCANNER_FIRST_FAIL_EN
    e_ff = 0;
    e_fv = 0;
`endif
    chk("stim",       d, int'(vec[d]),  e_vec);
    chk("busy",       d, int'(busy[d]), int'(e_busy));
    chk("done",       d, int'(done[d]), int'(e_done));
    chk("pass",       d, int'(pass[d]), int'(e_pass));
    chk("truth_tbl",  d, int'(tbl[d]),  int'(e_tbl));
    chk("mismatches", d, int'(mism[d]), e_mism);
    chk("first_fail", d, int'(ff[d]),   e_ff);
    chk("fail_valid", d, int'(fv[d]),   int'(e_fv));
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) check_dut(d);
  end

  // Starts a scan on dut d with function table tab. If extra_at >= 0, start is
  // also held high at edge extra_at+1 (counted from the accepting edge).
  // cyc returns the edge count at which done was first seen.
  task automatic run_scan(int d, logic [15:0] tab, int extra_at, output int cyc);
    bit got;
    @(posedge clk); #1;
    ftab[d]  = tab;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    cyc = 0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (cyc == extra_at) start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
      cyc++;
      if (done[d]) got = 1;
    end
    if (!got) begin
      n_assert++;
      n_fail++;
      $display("FAIL done_timeout dut%0d: got no done expected done within 400 clks", d);
    end
  endtask

  initial begin
    int cyc;
    bit got;
    int mt [9] = '{1, 2, 4, 5, 7, 8, 9, 10, 15};
    ref_tab = 16'h0000;
    foreach (mt[i]) ref_tab[mt[i]] = 1'b1;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", 0, int'(busy[0]), 0);
    chk("reset_tbl",  0, int'(tbl[0]),  0);

    // reference function
    run_scan(0, ref_tab, -1, cyc);
    chk("c1_latency",    0, cyc,           81);
    chk("c1_tbl",        0, int'(tbl[0]),  'h87B6);
    chk("c1_mismatches", 0, int'(mism[0]), 0);
    chk("c1_pass",       0, int'(pass[0]), 1);
    chk("c1_fail_valid", 0, int'(fv[0]),   0);

    // f stuck at 0
    run_scan(0, 16'h0000, -1, cyc);
    chk("c2_tbl",        0, int'(tbl[0]),  0);
    chk("c2_mismatches", 0, int'(mism[0]), 9);
    chk("c2_pass",       0, int'(pass[0]), 0);
`ifdef TRUTH_TABLE_SCANNER_FIRST_FAIL_EN
    chk("c2_first_fail", 0, int'(ff[0]),   1);
    chk("c2_fail_valid", 0, int'(fv[0]),   1);
`endif

    // inverted function
    run_scan(0, ~ref_tab, -1, cyc);
    chk("c3_tbl",        0, int'(tbl[0]),  'h7849);
    chk("c3_mismatches", 0, int'(mism[0]), 16);
    chk("c3_pass",       0, int'(pass[0]), 0);
`ifdef TRUTH_TABLE_SCANNER_FIRST_FAIL_EN
    chk("c3_first_fail", 0, int'(ff[0]),   0);
`endif

    // start re-pulsed while vector 5 is driven
    run_scan(0, ref_tab, 27, cyc);
    chk("c4_latency", 0, cyc,           81);
    chk("c4_tbl",     0, int'(tbl[0]),  'h87B6);
    chk("c4_pass",    0, int'(pass[0]), 1);

    // start coinciding with the edge that leaves DONE is ignored
    run_scan(0, 16'h0000, 80, cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("done_exit_start_busy", 0, int'(busy[0]), 0);
    chk("done_exit_start_mism", 0, int'(mism[0]), 9);

    // reset mid-scan while vector 7 is driven
    @(posedge clk); #1;
    ftab[0]  = ref_tab;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (vec[0] == 4'd7) got = 1;
    end
    chk("c5_reached_vec7", 0, int'(got), 1);
    #2 rst = 1'b1;
    #1;
    chk("c5_async_stim", 0, int'(vec[0]),  0);
    chk("c5_async_busy", 0, int'(busy[0]), 0);
    chk("c5_async_tbl",  0, int'(tbl[0]),  0);
    chk("c5_async_mism", 0, int'(mism[0]), 0);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    run_scan(0, ref_tab, -1, cyc);
    chk("c5_rescan_latency", 0, cyc,           81);
    chk("c5_rescan_pass",    0, int'(pass[0]), 1);

    // single settle cycle
    run_scan(1, ref_tab, -1, cyc);
    chk("c6_latency", 1, cyc,           33);
    chk("c6_tbl",     1, int'(tbl[1]),  'h87B6);
    chk("c6_pass",    1, int'(pass[1]), 1);

    // random functions with a random stray start somewhere in the scan
    for (int r = 0; r < 8; r++) begin
      int d;
      d = r % 2;
      run_scan(d, 16'($urandom), int'($urandom_range(0, span(d))), cyc);
      chk("rand_latency", d, cyc, span(d) + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
